// File: rtl/muldiv_wb_arbiter_pkg.sv
// Shared types and widths for the mult-unit writeback arbiter.
package muldiv_wb_arbiter_pkg;

  localparam int unsigned TRANS_ID_BITS = 4;
  localparam int unsigned XLEN          = 64;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SelNone,
    SelMult,
    SelFifo,
    SelDiv
  } sel_e;

endpackage

// File: rtl/muldiv_result_fifo.sv
// Generic synchronous FIFO with flush; wrap-bit pointers distinguish full from empty.
module muldiv_result_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AddrW:0]   wr_ptr;
  logic [AddrW:0]   rd_ptr;
  logic [Width-1:0] mem [Depth];

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                   (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
  assign rdata_o = mem[rd_ptr[AddrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/muldiv_wb_arbiter.sv
// Merges multiplier and divider results onto one writeback port; the multiplier always wins.
module muldiv_wb_arbiter #(
  parameter int unsigned TRANS_ID_BITS  = muldiv_wb_arbiter_pkg::TRANS_ID_BITS,
  parameter int unsigned XLEN           = muldiv_wb_arbiter_pkg::XLEN,
  parameter int unsigned DIV_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     mult_valid_i,
  input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
  input  logic [XLEN-1:0]          mult_result_i,
  input  logic                     div_valid_i,
  input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
  input  logic [XLEN-1:0]          div_result_i,
  output logic                     div_ready_o,
  output logic                     mult_hold_o,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     busy_o
);
  import muldiv_wb_arbiter_pkg::*;

  localparam int unsigned EntryW = TRANS_ID_BITS + XLEN;
  localparam int unsigned CntW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  logic              fifo_full;
  logic              fifo_empty;
  logic              div_hs;
  logic              push;
  logic              pop;
  logic [EntryW-1:0] fifo_head;
  logic [CntW-1:0]   starve_cnt;
  sel_e              sel;

  // Ready stays high during flush so the divider never stalls on a result about to be dropped.
  always_comb begin
    div_ready_o = !fifo_full || flush_i;
    div_hs      = div_valid_i && div_ready_o;
    sel         = SelNone;
    if (mult_valid_i)     sel = SelMult;
    else if (!fifo_empty) sel = SelFifo;
    else if (div_hs)      sel = SelDiv;
    pop  = (sel == SelFifo) && !flush_i;
    push = div_hs && (sel != SelDiv) && !flush_i;
  end

  muldiv_result_fifo #(
    .Width (EntryW),
    .Depth (DIV_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({div_trans_id_i, div_result_i}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o    <= 1'b0;
      wb_trans_id_o <= '0;
      wb_result_o   <= '0;
      starve_cnt    <= '0;
      mult_hold_o   <= 1'b0;
    end else begin
      wb_valid_o <= (sel != SelNone) && !flush_i;
      unique case (sel)
        SelMult: begin
          wb_trans_id_o <= mult_trans_id_i;
          wb_result_o   <= mult_result_i;
        end
        SelFifo: {wb_trans_id_o, wb_result_o} <= fifo_head;
        SelDiv: begin
          wb_trans_id_o <= div_trans_id_i;
          wb_result_o   <= div_result_i;
        end
        default: ;
      endcase
      if (flush_i || fifo_empty || pop) starve_cnt <= '0;
      else if (starve_cnt != StarveMax) starve_cnt <= starve_cnt + CntW'(1);
      // Counter holds at the limit until a pop, so hold stays up until then.
      mult_hold_o <= !flush_i && !pop && (starve_cnt == StarveMax);
    end
  end

  assign busy_o = !fifo_empty || wb_valid_o;

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Directed vector bench for the mult-unit writeback arbiter.
module tb_muldiv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mult_valid;
  logic [3:0]  mult_id;
  logic [63:0] mult_res;
  logic        div_valid;
  logic [3:0]  div_id;
  logic [63:0] div_res;
  logic        div_ready;
  logic        mult_hold;
  logic        wb_valid;
  logic [3:0]  wb_id;
  logic [63:0] wb_res;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_wb_arbiter #(
    .TRANS_ID_BITS  (4),
    .XLEN           (64),
    .DIV_FIFO_DEPTH (2),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .mult_valid_i    (mult_valid),
    .mult_trans_id_i (mult_id),
    .mult_result_i   (mult_res),
    .div_valid_i     (div_valid),
    .div_trans_id_i  (div_id),
    .div_result_i    (div_res),
    .div_ready_o     (div_ready),
    .mult_hold_o     (mult_hold),
    .wb_valid_o      (wb_valid),
    .wb_trans_id_o   (wb_id),
    .wb_result_o     (wb_res),
    .busy_o          (busy)
  );

  typedef struct {
    logic        mv;
    logic [3:0]  mid;
    logic [63:0] mres;
    logic        dv;
    logic [3:0]  did;
    logic [63:0] dres;
    logic        ev;
    logic [3:0]  eid;
    logic [63:0] eres;
    logic        erdy;
    logic        ebusy;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [3:0] mid, input logic [63:0] mres,
                       input logic dv, input logic [3:0] did, input logic [63:0] dres,
                       input logic fl);
    mult_valid = mv;
    mult_id    = mid;
    mult_res   = mres;
    div_valid  = dv;
    div_id     = did;
    div_res    = dres;
    flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string name, input logic [3:0] id, input logic [63:0] res);
    chk({name, "_valid"}, 64'(wb_valid), 64'd1);
    chk({name, "_id"}, 64'(wb_id), 64'(id));
    chk({name, "_res"}, wb_res, res);
  endtask

  initial begin
    // {mv, mid, mres, dv, did, dres, exp_valid, exp_id, exp_res, exp_ready, exp_busy}
    vecs[0] = '{1'b1, 4'd3, 64'h1234, 1'b0, 4'd0, 64'h0,  1'b1, 4'd3, 64'h1234, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 64'h0,  1'b0, 4'd0, 64'h0,    1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'd1, 64'hAA,   1'b1, 4'd2, 64'hBB, 1'b1, 4'd1, 64'hAA,   1'b1, 1'b1};
    vecs[3] = '{1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 64'h0,  1'b1, 4'd2, 64'hBB,   1'b1, 1'b1};
    vecs[4] = '{1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 64'h0,  1'b0, 4'd0, 64'h0,    1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 64'h0,    1'b1, 4'd6, 64'h66, 1'b1, 4'd6, 64'h66,   1'b1, 1'b1};
    vecs[6] = '{1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 64'h0,  1'b0, 4'd0, 64'h0,    1'b1, 1'b0};

    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_id", 64'(wb_id), 64'd0);
    chk("rst_wb_res", wb_res, 64'd0);
    chk("rst_hold", 64'(mult_hold), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(div_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_wb_valid", 64'(wb_valid), 64'd0);
      chk("idle_ready", 64'(div_ready), 64'd1);
      chk("idle_hold", 64'(mult_hold), 64'd0);
    end

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].mv, vecs[i].mid, vecs[i].mres, vecs[i].dv, vecs[i].did, vecs[i].dres, 1'b0);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(wb_valid), 64'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_id", i), 64'(wb_id), 64'(vecs[i].eid));
        chk($sformatf("vec%0d_res", i), wb_res, vecs[i].eres);
      end
      chk($sformatf("vec%0d_ready", i), 64'(div_ready), 64'(vecs[i].erdy));
      chk($sformatf("vec%0d_hold", i), 64'(mult_hold), 64'd0);
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].ebusy));
    end

    // Starvation: div id5 buffered behind a continuous multiplier stream.
    drive(1'b1, 4'd1, 64'hAA, 1'b1, 4'd5, 64'h55, 1'b0);
    tick();
    chk_wb("starve_first", 4'd1, 64'hAA);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd2, 64'h22, 1'b0, 4'd0, 64'h0, 1'b0);
      tick();
      chk($sformatf("starve_hold_low%0d", i), 64'(mult_hold), 64'd0);
    end
    tick();
    chk("starve_hold_rise", 64'(mult_hold), 64'd1);
    // One multiplication was already issued as hold rose and still arrives.
    tick();
    chk("starve_hold_inflight", 64'(mult_hold), 64'd1);
    chk_wb("starve_inflight", 4'd2, 64'h22);
    idle();
    tick();
    chk_wb("starve_pop", 4'd5, 64'h55);
    chk("starve_hold_drop", 64'(mult_hold), 64'd0);
    tick();
    chk("starve_drained_busy", 64'(busy), 64'd0);

    // FIFO full and back-pressure on the divider.
    drive(1'b1, 4'd1, 64'h11, 1'b1, 4'd7, 64'h77, 1'b0);
    tick();
    chk("full_a_ready", 64'(div_ready), 64'd1);
    drive(1'b1, 4'd1, 64'h11, 1'b1, 4'd8, 64'h88, 1'b0);
    tick();
    chk("full_b_ready", 64'(div_ready), 64'd0);
    drive(1'b1, 4'd1, 64'h11, 1'b1, 4'd9, 64'h99, 1'b0);
    tick();
    chk("full_c_ready", 64'(div_ready), 64'd0);
    chk_wb("full_c_mult", 4'd1, 64'h11);
    drive(1'b0, 4'd0, 64'h0, 1'b1, 4'd9, 64'h99, 1'b0);
    tick();
    chk_wb("full_pop7", 4'd7, 64'h77);
    chk("full_d_ready", 64'(div_ready), 64'd1);
    tick();
    chk_wb("full_pop8", 4'd8, 64'h88);
    chk("full_e_ready", 64'(div_ready), 64'd1);
    idle();
    tick();
    chk_wb("full_pop9", 4'd9, 64'h99);
    tick();
    chk("full_end_valid", 64'(wb_valid), 64'd0);
    chk("full_end_busy", 64'(busy), 64'd0);

    // Flush with two buffered entries and a multiplier result in flight.
    drive(1'b1, 4'd3, 64'h31, 1'b1, 4'd10, 64'hA0, 1'b0);
    tick();
    drive(1'b1, 4'd3, 64'h32, 1'b1, 4'd11, 64'hB0, 1'b0);
    tick();
    chk("flush_pre_ready", 64'(div_ready), 64'd0);
    drive(1'b1, 4'd3, 64'h33, 1'b1, 4'd12, 64'hC0, 1'b1);
    #1;
    chk("flush_cycle_ready", 64'(div_ready), 64'd1);
    tick();
    idle();
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready", 64'(div_ready), 64'd1);
    chk("flush_hold", 64'(mult_hold), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush_quiet%0d", i), 64'(wb_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
